// File: rtl/ms_window_acc_pkg.sv
// Shared types and sizing helpers for the mean-square window accumulator.
package ms_window_acc_pkg;

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Accumulator sized so a full window of maximum squares cannot overflow.
  function automatic int unsigned acc_width(input int unsigned sample_width,
                                            input int unsigned log2_win);
    return 2 * sample_width + log2_win;
  endfunction

endpackage

// File: rtl/ms_square_sat.sv
// Signed square of one sample added to the running sum, plus the window mean
// (right shift) clamped to the largest positive radicand.
module ms_square_sat #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned LOG2_WIN     = 4,
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned ACC_WIDTH    = 2 * SAMPLE_WIDTH + LOG2_WIN
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic        [ACC_WIDTH-1:0]    acc,
  output logic        [ACC_WIDTH-1:0]    sum_c,
  output logic        [OUT_WIDTH-1:0]    mean_c,
  output logic                           clamp_c
);

  localparam int unsigned SQ_W  = 2 * SAMPLE_WIDTH;
  localparam int unsigned CMP_W = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;
  localparam logic [CMP_W-1:0] MAX_POS =
    {{(CMP_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};

  logic signed [SQ_W-1:0]  ext;
  logic signed [SQ_W-1:0]  sq;
  logic        [CMP_W-1:0] mean_w;

  // The product always fits: the largest square is 2**(SQ_W-2).
  assign ext    = {{SAMPLE_WIDTH{sample[SAMPLE_WIDTH-1]}}, sample};
  assign sq     = ext * ext;
  assign sum_c  = acc + ACC_WIDTH'($unsigned(sq));
  assign mean_w = CMP_W'(sum_c >> LOG2_WIN);

  assign clamp_c = mean_w > MAX_POS;
  assign mean_c  = clamp_c ? MAX_POS[OUT_WIDTH-1:0] : mean_w[OUT_WIDTH-1:0];

endmodule

// File: rtl/ms_window_acc.sv
// Accumulates squared samples over a power-of-two window and hands the mean
// square to the iterative root stage with a start/done handshake.
module ms_window_acc
  import ms_window_acc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned LOG2_WIN     = 4,
  parameter int unsigned OUT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  output logic                           sq_start,
  output logic signed [OUT_WIDTH-1:0]    sq_x,
  input  logic                           sq_done,
  input  logic                           sq_is_neg,
  output logic        [7:0]              win_cnt,
  output logic                           sat,
  output logic                           neg_err
);

  localparam int unsigned ACC_WIDTH = acc_width(SAMPLE_WIDTH, LOG2_WIN);
  localparam int unsigned CNT_W     = LOG2_WIN + 1;
  localparam int unsigned WIN       = 1 << LOG2_WIN;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 start_q;
  logic [ACC_WIDTH-1:0] sum_c;
  logic [OUT_WIDTH-1:0] mean_c;
  logic                 clamp_c;
  logic                 accept_c;
  logic                 last_c;

  ms_square_sat #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .LOG2_WIN    (LOG2_WIN),
    .OUT_WIDTH   (OUT_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_square_sat (
    .sample (sample_in),
    .acc    (acc),
    .sum_c  (sum_c),
    .mean_c (mean_c),
    .clamp_c(clamp_c)
  );

  assign accept_c = sample_valid & sample_ready;
  assign last_c   = (cnt == CNT_W'(WIN - 1));

  // clear must suppress a start pulse already sitting in the register.
  assign sq_start = start_q & ~clear;

  // Window FSM, counters and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      start_q      <= 1'b0;
      sample_ready <= 1'b0;
      sq_x         <= '0;
      win_cnt      <= '0;
      sat          <= 1'b0;
      neg_err      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (clear) begin
        state        <= ACC;
        acc          <= '0;
        cnt          <= '0;
        sample_ready <= 1'b1;
      end else begin
        case (state)
          ACC: begin
            sample_ready <= 1'b1;
            if (accept_c) begin
              acc <= sum_c;
              cnt <= cnt + CNT_W'(1);
              if (last_c) begin
                sq_x         <= mean_c;
                sat          <= sat | clamp_c;
                start_q      <= 1'b1;
                sample_ready <= 1'b0;
                state        <= LAUNCH;
              end
            end
          end
          LAUNCH: state <= WAIT;
          WAIT: begin
            if (sq_done) begin
              neg_err      <= neg_err | sq_is_neg;
              win_cnt      <= win_cnt + 8'd1;
              acc          <= '0;
              cnt          <= '0;
              sample_ready <= 1'b1;
              state        <= ACC;
            end
          end
          default: begin
            sample_ready <= 1'b1;
            state        <= ACC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ms_window_acc.sv
// Scoreboard bench for ms_window_acc: directed windows with a modelled root
// stage, plus a narrow-output instance that exercises the clamp.
module tb_ms_window_acc;

  localparam int WIN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               clear;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  wire                sample_ready;
  wire                sq_start;
  wire         [31:0] sq_x;
  wire         [7:0]  win_cnt;
  wire                sat;
  wire                neg_err;

  logic rsp_done   = 1'b0;
  logic rsp_neg    = 1'b0;
  logic stray_done = 1'b0;
  logic stray_neg  = 1'b0;
  wire  sq_done_w  = rsp_done | stray_done;
  wire  sq_neg_w   = rsp_neg | stray_neg;

  logic               s_clear = 1'b0;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_in    = '0;
  logic               s_done  = 1'b0;
  logic               s_neg   = 1'b0;
  wire                s_ready;
  wire                s_start;
  wire         [30:0] s_x;
  wire         [7:0]  s_win;
  wire                s_sat;
  wire                s_nerr;

  ms_window_acc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_in   (sample_in),
    .sq_start    (sq_start),
    .sq_x        (sq_x),
    .sq_done     (sq_done_w),
    .sq_is_neg   (sq_neg_w),
    .win_cnt     (win_cnt),
    .sat         (sat),
    .neg_err     (neg_err)
  );

  ms_window_acc #(.SAMPLE_WIDTH(16), .LOG2_WIN(0), .OUT_WIDTH(31)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (s_clear),
    .sample_valid(s_valid),
    .sample_ready(s_ready),
    .sample_in   (s_in),
    .sq_start    (s_start),
    .sq_x        (s_x),
    .sq_done     (s_done),
    .sq_is_neg   (s_neg),
    .win_cnt     (s_win),
    .sat         (s_sat),
    .neg_err     (s_nerr)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          win_acc = 0;
  int          last_acc = 0;
  bit          busy = 1'b0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  bit          rsp_en = 1'b1;
  bit          rsp_neg_cfg = 1'b0;
  int          rsp_delay = 3;
  int          cd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Root-stage model: done pulse rsp_delay cycles after the start pulse.
  initial forever begin
    @(posedge clk);
    #2;
    rsp_done = 1'b0;
    rsp_neg  = 1'b0;
    if (!rst_n) cd = 0;
    else if (rsp_en && sq_start) cd = rsp_delay;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        rsp_done = 1'b1;
        rsp_neg  = rsp_neg_cfg;
        done_cyc = cyc;
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse and polices the handshake.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst_n) begin
      win_acc = 0;
      busy    = 1'b0;
    end else begin
      if (sq_start) begin
        chk("start_one_cycle", 64'(busy), 64'd0);
        chk("start_after_full_window", 64'(win_acc), 64'(WIN));
        chk("start_latency", 64'(last_acc), 64'(cyc - 1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got sq_x=%0d expected no start", sq_x);
        end else begin
          e = exp_q.pop_front();
          chk("sq_x", 64'(sq_x), 64'(e));
        end
        busy    = 1'b1;
        win_acc = 0;
      end else if (busy) begin
        chk("ready_low_while_busy", 64'(sample_ready), 64'd0);
      end
      if (sample_valid && sample_ready && !clear) begin
        win_acc++;
        last_acc = cyc;
      end
      if (clear) begin
        busy    = 1'b0;
        win_acc = 0;
      end else if (busy && sq_done_w && !sq_start) begin
        busy = 1'b0;
      end
    end
  end

  task automatic send(input logic signed [15:0] v);
    int t;
    t = 0;
    sample_in    = v;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=%0d expected 1 within 100 cycles", sample_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (sample_ready !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%0d expected 1 within 100 cycles", sample_ready);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic pulse_stray();
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_ready", 64'(sample_ready), 64'd0);
    chk("rst_start", 64'(sq_start), 64'd0);
    chk("rst_sq_x", 64'(sq_x), 64'd0);
    chk("rst_win_cnt", 64'(win_cnt), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_neg_err", 64'(neg_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    #1;
    check_reset();
    chk("rst_sat_inst_sat", 64'(s_sat), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant 3s: mean 144 >> 4 = 9.
    exp_q.push_back(32'd9);
    send_n(16'sd3, 16);
    wait_ready();
    chk("win_cnt_after_w1", 64'(win_cnt), 64'd1);

    // Most negative sample: 2**34 >> 4 = 2**30, no clamp.
    exp_q.push_back(32'd1073741824);
    send_n(-16'sd32768, 16);
    wait_ready();
    chk("win_cnt_after_w2", 64'(win_cnt), 64'd2);
    chk("sat_extreme", 64'(sat), 64'd0);

    // Backpressure with a slow root stage: 1496 >> 4 = 93.
    rsp_delay = 20;
    exp_q.push_back(32'd93);
    for (int i = 1; i <= 16; i++) send(16'(i));
    send(16'sd17);
    chk("accept_after_done", 64'(acc_cyc), 64'(done_cyc + 1));
    chk("win_cnt_after_w3", 64'(win_cnt), 64'd3);
    for (int i = 18; i <= 20; i++) send(16'(i));
    rsp_delay = 3;

    // Flush a partial window, then a clean window of 2s.
    send_n(16'sd100, 7);
    pulse_clear();
    chk("sq_x_kept_on_clear", 64'(sq_x), 64'd93);
    chk("win_kept_on_clear", 64'(win_cnt), 64'd3);
    exp_q.push_back(32'd4);
    send_n(16'sd2, 16);
    wait_ready();
    chk("win_cnt_after_w4", 64'(win_cnt), 64'd4);

    // Asynchronous reset mid-window.
    send_n(16'sd100, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(32'd25);
    send_n(16'sd5, 16);
    wait_ready();
    chk("win_cnt_after_reset", 64'(win_cnt), 64'd1);
    chk("neg_err_clean", 64'(neg_err), 64'd0);

    // Negative flag from the root stage is sticky.
    rsp_neg_cfg = 1'b1;
    exp_q.push_back(32'd1);
    send_n(16'sd1, 16);
    wait_ready();
    rsp_neg_cfg = 1'b0;
    chk("neg_err_set", 64'(neg_err), 64'd1);
    exp_q.push_back(32'd16);
    send_n(16'sd4, 16);
    wait_ready();
    chk("neg_err_sticky", 64'(neg_err), 64'd1);
    chk("win_cnt_after_neg", 64'(win_cnt), 64'd3);

    // Stray done while accumulating: no effect on count or window length.
    exp_q.push_back(32'd64);
    send_n(16'sd8, 3);
    pulse_stray();
    chk("win_cnt_stray_acc", 64'(win_cnt), 64'd3);
    send_n(16'sd8, 13);
    wait_ready();
    chk("win_cnt_after_stray", 64'(win_cnt), 64'd4);

    // Clear while waiting on the root: handshake abandoned, late done ignored.
    rsp_en = 1'b0;
    exp_q.push_back(32'd36);
    send_n(16'sd6, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("ready_low_in_wait", 64'(sample_ready), 64'd0);
    pulse_clear();
    chk("ready_after_wait_clear", 64'(sample_ready), 64'd1);
    chk("sq_x_kept_wait_clear", 64'(sq_x), 64'd36);
    pulse_stray();
    chk("win_cnt_stray_after_clear", 64'(win_cnt), 64'd4);
    rsp_en = 1'b1;
    exp_q.push_back(32'd49);
    send_n(16'sd7, 16);
    wait_ready();
    chk("win_cnt_after_w5", 64'(win_cnt), 64'd5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // One-sample window into a 31-bit radicand: 2**30 clamps to 2**30-1.
    begin
      int t;
      t = 0;
      while (s_ready !== 1'b1 && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("sat_inst_ready", 64'(s_ready), 64'd1);
      s_in    = -16'sd32768;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("sat_inst_start", 64'(s_start), 64'd1);
      chk("sat_inst_sq_x", 64'(s_x), 64'd1073741823);
      chk("sat_inst_sat", 64'(s_sat), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      s_done = 1'b1;
      @(posedge clk);
      #1;
      s_done = 1'b0;
      @(posedge clk);
      #1;
      chk("sat_inst_win_cnt", 64'(s_win), 64'd1);
      chk("sat_inst_sat_sticky", 64'(s_sat), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
